// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter, 8N1 LSB first (even parity bit added when UART_PARITY_EN is defined).
// Reads return one cycle after en_i; a TXDATA push reaches tx_o in 2 cycles; pushes to a full FIFO are dropped and set ovf.
module uart_tx_periph #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [3:0]  we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

`ifdef UART_PARITY_EN
    localparam state_t DATA_NEXT   = ST_PARITY;
    localparam logic   PARITY_FLAG = 1'b1;
`else
    localparam state_t DATA_NEXT   = ST_STOP;
    localparam logic   PARITY_FLAG = 1'b0;
`endif

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic          push_req, push_ok, pop;

    state_t        state_q, state_d;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [2:0]    bit_idx_q;
    logic [15:0]   baud_q, act_div_q, div_q;
    logic          bit_end, line_val, busy;

    logic          irqen_q, ovf_q, tx_q, irq_q;
    logic          wr_acc, rd_acc;
    logic [1:0]    reg_sel;
    logic [31:0]   status, rdata_d;
    logic          unused_bits;

    assign unused_bits = ^{addr_i[1:0], data_i[31:16]};

    assign reg_sel  = addr_i[3:2];
    assign wr_acc   = en_i && (we_i != 4'b0000);
    assign rd_acc   = en_i && (we_i == 4'b0000);
    assign push_req = wr_acc && (reg_sel == 2'd0) && we_i[0];

    assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign push_ok    = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                fifo_cnt <= fifo_cnt + (AW+1)'(1);
            else if (pop && !push_ok)
                fifo_cnt <= fifo_cnt - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= data_i[7:0];
    end

    assign bit_end = (baud_q == 16'd0);
    assign busy    = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_START;
                    pop     = 1'b1;
                end
            end
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA:   if (bit_end && (bit_idx_q == 3'd7)) state_d = DATA_NEXT;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        state_d = ST_START;
                        pop     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        line_val = 1'b1;
        case (state_q)
            ST_START:  line_val = 1'b0;
            ST_DATA:   line_val = shift_q[0];
            ST_PARITY: line_val = par_q;
            default:   line_val = 1'b1;
        endcase
    end

    // Divisor is captured at every frame start so mid-frame DIV writes never stretch a bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            bit_idx_q <= 3'd0;
            baud_q    <= 16'd0;
            act_div_q <= 16'd0;
        end else if (pop) begin
            shift_q   <= fifo_mem[rd_ptr];
            par_q     <= ^fifo_mem[rd_ptr];
            bit_idx_q <= 3'd0;
            baud_q    <= div_q;
            act_div_q <= div_q;
        end else if (busy) begin
            if (bit_end) begin
                baud_q <= act_div_q;
                if (state_q == ST_DATA) begin
                    shift_q   <= shift_q >> 1;
                    bit_idx_q <= bit_idx_q + 3'd1;
                end
            end else begin
                baud_q <= baud_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q   <= DEFAULT_DIV;
            irqen_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_acc && (reg_sel == 2'd2)) begin
                if (we_i[0]) div_q[7:0]  <= data_i[7:0];
                if (we_i[1]) div_q[15:8] <= data_i[15:8];
            end
            if (wr_acc && (reg_sel == 2'd3) && we_i[0])
                irqen_q <= data_i[0];
            if (push_req && !push_ok)
                ovf_q <= 1'b1;
            else if (wr_acc && (reg_sel == 2'd1) && we_i[0] && data_i[3])
                ovf_q <= 1'b0;
        end
    end

    always_comb begin
        status           = 32'd0;
        status[0]        = busy;
        status[1]        = fifo_full;
        status[2]        = fifo_empty;
        status[3]        = ovf_q;
        status[4]        = PARITY_FLAG;
        status[8 +: AW+1] = fifo_cnt;
    end

    always_comb begin
        rdata_d = 32'd0;
        case (reg_sel)
            2'd1:    rdata_d = status;
            2'd2:    rdata_d = {16'd0, div_q};
            2'd3:    rdata_d = {31'd0, irqen_q};
            default: rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_q   <= 1'b1;
            irq_q  <= 1'b0;
            data_o <= 32'd0;
        end else begin
            tx_q  <= line_val;
            irq_q <= irqen_q & fifo_empty & ~busy;
            if (rd_acc) data_o <= rdata_d;
        end
    end

    assign tx_o  = tx_q;
    assign irq_o = irq_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Randomised and directed bench for uart_tx_periph against a queue-based line model.
module tb_uart_tx_periph;
    localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
    localparam int          NB  = 11;
    localparam bit          PAR = 1'b1;
    localparam logic [10:0] P55 = 11'b10010101010;
`else
    localparam int          NB  = 10;
    localparam bit          PAR = 1'b0;
    localparam logic [10:0] P55 = 11'b01010101010;
`endif
    localparam logic [31:0] SP = PAR ? 32'h10 : 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_i;
    logic [3:0]  we_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx_o;
    logic        irq_o;

    int total = 0;
    int bad   = 0;

    uart_tx_periph dut (
        .clk    (clk),
        .reset  (reset),
        .en_i   (en_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .tx_o   (tx_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: queued bytes plus the exact line levels still to be driven.
    logic [7:0]  mq[$];
    bit          wave[$];
    logic [15:0] m_div;
    bit          m_irqen, m_ovf, m_valid;
    logic        m_tx, m_irq;
    logic [31:0] m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add_frame(input logic [7:0] b, input logic [15:0] d);
        bit lv[$];
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(b[i]);
        if (PAR) lv.push_back(^b);
        lv.push_back(1'b1);
        foreach (lv[j])
            for (int r = 0; r <= int'(d); r++) wave.push_back(lv[j]);
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] sel, input int cnt, input bit bsy);
        logic [31:0] v;
        v = 32'd0;
        case (sel)
            2'd1:    v = {16'd0, 8'(cnt), 3'b000, PAR, m_ovf, cnt == 0, cnt == DEPTH, bsy};
            2'd2:    v = {16'd0, m_div};
            2'd3:    v = {31'd0, m_irqen};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    initial begin
        int  cnt;
        bit  bsy, irq_n, do_pop;
        m_valid = 1'b0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                mq.delete();
                wave.delete();
                m_div   = 16'd867;
                m_irqen = 1'b0;
                m_ovf   = 1'b0;
                m_tx    = 1'b1;
                m_irq   = 1'b0;
                m_data  = 32'd0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                cnt   = mq.size();
                bsy   = (wave.size() != 0);
                irq_n = m_irqen && (cnt == 0) && !bsy;
                if (en_i && (we_i == 4'd0)) m_data = m_read(addr_i[3:2], cnt, bsy);
                m_tx   = (wave.size() != 0) ? wave.pop_front() : 1'b1;
                do_pop = (wave.size() == 0) && (cnt != 0);
                if (do_pop) add_frame(mq.pop_front(), m_div);
                if (en_i && (we_i != 4'd0)) begin
                    case (addr_i[3:2])
                        2'd0: if (we_i[0]) begin
                            if (cnt < DEPTH || do_pop) mq.push_back(data_i[7:0]);
                            else m_ovf = 1'b1;
                        end
                        2'd1: if (we_i[0] && data_i[3]) m_ovf = 1'b0;
                        2'd2: begin
                            if (we_i[0]) m_div[7:0]  = data_i[7:0];
                            if (we_i[1]) m_div[15:8] = data_i[15:8];
                        end
                        default: if (we_i[0]) m_irqen = data_i[0];
                    endcase
                end
                m_irq = irq_n;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("tx_o", {31'd0, tx_o}, {31'd0, m_tx});
                check("irq_o", {31'd0, irq_o}, {31'd0, m_irq});
                check("data_o", data_o, m_data);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic bus_wr(input logic [3:0] a, input logic [3:0] w, input logic [31:0] d);
        en_i = 1'b1; we_i = w; addr_i = a; data_i = d;
        @(negedge clk);
        en_i = 1'b0; we_i = 4'd0; addr_i = 4'd0; data_i = 32'd0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        en_i = 1'b1; we_i = 4'd0; addr_i = a;
        @(negedge clk);
        en_i = 1'b0; addr_i = 4'd0;
        d = data_o;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((wave.size() != 0 || mq.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", {31'd0, n < limit}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [10:0] pat;
        logic [3:0]  held;
        logic        samp_tx [0:63];
        int          busy_cnt, k, lows;

        en_i = 1'b0; we_i = 4'd0; addr_i = 4'd0; data_i = 32'd0; reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst_tx", {31'd0, tx_o}, 32'd1);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        bus_rd(4'h4, r); check("rst_status", r, 32'h4 | SP);
        bus_rd(4'h8, r); check("rst_div", r, 32'h363);

        // 0x55 at DIV=3: latency, bit levels and busy duration
        bus_wr(4'h8, 4'b0011, 32'd3);
        bus_wr(4'h0, 4'b0001, 32'h55);
        samp_tx[0] = tx_o;
        en_i = 1'b1; we_i = 4'd0; addr_i = 4'h4;
        busy_cnt = 0;
        for (int i = 1; i <= NB*4 + 4; i++) begin
            @(negedge clk);
            samp_tx[i] = tx_o;
            if (data_o[0]) busy_cnt++;
        end
        en_i = 1'b0; addr_i = 4'd0;
        check("lat_k0", {31'd0, samp_tx[0]}, 32'd1);
        check("lat_k1", {31'd0, samp_tx[1]}, 32'd1);
        check("lat_k2", {31'd0, samp_tx[2]}, 32'd0);
        pat = P55;
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < 4; j++) held[j] = samp_tx[2 + 4*b + j];
            check($sformatf("f55_bit%0d", b), {28'd0, held}, {28'd0, {4{pat[b]}}});
        end
        check("busy_cycles", busy_cnt, NB*4);
        drain(200);

        // DIV=0 back-to-back frames
        bus_wr(4'h8, 4'b0011, 32'd0);
        bus_wr(4'h0, 4'b0001, 32'hA5);
        bus_wr(4'h0, 4'b0001, 32'h3C);
        bus_rd(4'h4, r); check("b2b_cnt1", r, 32'h101 | SP);
        repeat (NB - 1) @(negedge clk);
        bus_rd(4'h4, r); check("b2b_cnt0", r, 32'h5 | SP);
        drain(200);

        // Overflow with DIV=100
        bus_wr(4'h8, 4'b0011, 32'd100);
        for (int i = 0; i < 10; i++) bus_wr(4'h0, 4'b0001, 32'h30 + i);
        bus_rd(4'h4, r); check("ovf_set", r, 32'h80B | SP);
        bus_wr(4'h4, 4'b0001, 32'h8);
        bus_rd(4'h4, r); check("ovf_clr", r, 32'h803 | SP);
        bus_wr(4'h8, 4'b0011, 32'd1);
        drain(5000);

        // Interrupt
        bus_wr(4'hC, 4'b0001, 32'd1);
        repeat (2) @(negedge clk);
        check("irq_idle", {31'd0, irq_o}, 32'd1);
        bus_wr(4'h0, 4'b0001, 32'h00);
        check("irq_k0", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        check("irq_k1", {31'd0, irq_o}, 32'd0);
        k = 1;
        while (!irq_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("irq_rise", k, 2*NB + 2);
        bus_wr(4'h0, 4'b0001, 32'h41);
        check("irq_push_k0", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        check("irq_push_k1", {31'd0, irq_o}, 32'd0);
        drain(200);
        bus_wr(4'hC, 4'b0001, 32'd0);
        repeat (2) @(negedge clk);
        check("irq_dis", {31'd0, irq_o}, 32'd0);

        // Reset during DATA bit 3
        bus_wr(4'h8, 4'b0011, 32'd3);
        bus_wr(4'h0, 4'b0001, 32'hF0);
        bus_wr(4'h0, 4'b0001, 32'h11);
        bus_wr(4'h0, 4'b0001, 32'h22);
        repeat (15) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_tx", {31'd0, tx_o}, 32'd1);
        bus_rd(4'h4, r); check("midrst_status", r, 32'h4 | SP);
        bus_rd(4'h8, r); check("midrst_div", r, 32'h363);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!tx_o) lows++;
        end
        check("midrst_quiet", lows, 0);

        // Random traffic
        bus_wr(4'h8, 4'b0011, 32'd2);
        for (int i = 0; i < 3000; i++) begin
            en_i   = ($urandom_range(0, 3) == 0);
            addr_i = {2'($urandom_range(0, 3)), 2'($urandom)};
            we_i   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            data_i = $urandom;
            if (addr_i[3:2] == 2'd2) data_i[15:0] = {8'd0, 8'($urandom_range(0, 3))};
            @(negedge clk);
        end
        en_i = 1'b0; we_i = 4'd0; addr_i = 4'd0; data_i = 32'd0;
        drain(5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
